// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, FSM encoding and defaults for the data-memory access controller.
package mem_ctrl_pkg;

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_STORE  = 3'd1;
    localparam logic [2:0] OP_PUSH   = 3'd2;
    localparam logic [2:0] OP_POP    = 3'd3;
    localparam logic [2:0] OP_PUSH32 = 3'd4;
    localparam logic [2:0] OP_POP32  = 3'd5;

    localparam int          MEM_DEPTH_DEF = 4096;
    localparam logic [15:0] STACK_TOP_DEF = 16'h0FFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Number of memory words an operation touches.
    function automatic logic [1:0] word_count(input logic [2:0] op);
        return ((op == OP_PUSH32) || (op == OP_POP32)) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with push/pop legality checks and a commit strobe.
module stack_pointer
    import mem_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_TOP  = STACK_TOP_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_commit,
    input  logic [2:0]            i_op,
    output logic [ADDR_WIDTH-1:0] o_sp,
    output logic [ADDR_WIDTH-1:0] o_sp_p1,
    output logic [ADDR_WIDTH-1:0] o_sp_p2,
    output logic [ADDR_WIDTH-1:0] o_sp_m1,
    output logic                  o_push_ok,
    output logic                  o_push32_ok,
    output logic                  o_pop_ok,
    output logic                  o_pop32_ok
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    logic [ADDR_WIDTH-1:0] sp_q, sp_d;

    // SP points at the next free slot; all arithmetic wraps at ADDR_WIDTH bits.
    assign o_sp        = sp_q;
    assign o_sp_p1     = sp_q + ONE;
    assign o_sp_p2     = sp_q + TWO;
    assign o_sp_m1     = sp_q - ONE;
    assign o_push_ok   = (sp_q != '1);
    assign o_push32_ok = (sp_q >= ONE);
    assign o_pop_ok    = (o_sp_p1 <= STACK_TOP);
    assign o_pop32_ok  = (o_sp_p2 <= STACK_TOP);

    // Apply the op's SP adjustment when the access sequence completes.
    always_comb begin
        sp_d = sp_q;
        if (i_commit) begin
            case (i_op)
                OP_PUSH:   sp_d = o_sp_m1;
                OP_POP:    sp_d = o_sp_p1;
                OP_PUSH32: sp_d = sp_q - TWO;
                OP_POP32:  sp_d = o_sp_p2;
                default:   sp_d = sp_q;
            endcase
        end
    end

    // SP register; reset restores the empty-stack value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sp_q <= STACK_TOP;
        else          sp_q <= sp_d;
    end

endmodule

// File: rtl/mem_access_controller.sv
// Turns one pipeline memory request into one or two single-word data-memory
// accesses, owns the stack pointer and reports completion or error.
//
// Handshake: a request is taken on the posedge where i_req_valid && o_ready.
// o_ready is high only in IDLE; a request presented while o_ready is low is
// ignored, not queued. o_resp_valid pulses for exactly one cycle per accepted
// request and qualifies o_error; o_resp_data holds until the next response.
module mem_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] STACK_TOP  = STACK_TOP_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    input  logic [2:0]              i_op,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [2*DATA_WIDTH-1:0] i_data,
    output logic                    o_ready,
    output logic                    o_resp_valid,
    output logic [2*DATA_WIDTH-1:0] o_resp_data,
    output logic                    o_error,
    output logic [ADDR_WIDTH-1:0]   o_sp,
    output logic [ADDR_WIDTH-1:0]   o_mem_address,
    output logic [DATA_WIDTH-1:0]   o_mem_write_data,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    input  logic [DATA_WIDTH-1:0]   i_mem_read_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_e                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0]   wdata1_q, wdata1_d;
    logic [DATA_WIDTH-1:0]   rd_lo_q, rd_lo_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    error_q, error_d;
    logic [2*DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                    commit;

    logic [ADDR_WIDTH-1:0]   sp, sp_p1, sp_p2, sp_m1;
    logic                    push_ok, push32_ok, pop_ok, pop32_ok;

    logic                    dec_legal, dec_read;
    logic [ADDR_WIDTH-1:0]   dec_a0, dec_a1;
    logic [DATA_WIDTH-1:0]   dec_w0, dec_w1;
    logic                    addr_in_range;

    stack_pointer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STACK_TOP  (STACK_TOP)
    ) u_sp (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_commit    (commit),
        .i_op        (op_q),
        .o_sp        (sp),
        .o_sp_p1     (sp_p1),
        .o_sp_p2     (sp_p2),
        .o_sp_m1     (sp_m1),
        .o_push_ok   (push_ok),
        .o_push32_ok (push32_ok),
        .o_pop_ok    (pop_ok),
        .o_pop32_ok  (pop32_ok)
    );

    assign addr_in_range    = ({1'b0, i_addr} < DEPTH_W);
    assign o_ready          = (state_q == ST_IDLE);
    assign o_resp_valid     = resp_valid_q;
    assign o_resp_data      = resp_data_q;
    assign o_error          = error_q;
    assign o_sp             = sp;
    assign o_mem_address    = mem_addr_q;
    assign o_mem_write_data = mem_wdata_q;
    assign o_mem_read       = mem_read_q;
    assign o_mem_write      = mem_write_q;

    // Decode the incoming request: legality, direction and both word addresses/data.
    always_comb begin
        dec_legal = 1'b0;
        dec_read  = 1'b0;
        dec_a0    = i_addr;
        dec_a1    = i_addr;
        dec_w0    = i_data[DATA_WIDTH-1:0];
        dec_w1    = i_data[DATA_WIDTH-1:0];
        case (i_op)
            OP_LOAD:   begin dec_legal = addr_in_range; dec_read = 1'b1; end
            OP_STORE:  begin dec_legal = addr_in_range; end
            OP_PUSH:   begin dec_legal = push_ok; dec_a0 = sp; end
            OP_POP:    begin dec_legal = pop_ok; dec_read = 1'b1; dec_a0 = sp_p1; end
            OP_PUSH32: begin
                dec_legal = push32_ok;
                dec_a0    = sp;
                dec_a1    = sp_m1;
                dec_w0    = i_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            OP_POP32:  begin
                dec_legal = pop32_ok;
                dec_read  = 1'b1;
                dec_a0    = sp_p1;
                dec_a1    = sp_p2;
            end
            default:   dec_legal = 1'b0;
        endcase
    end

    // FSM next state, memory controls and response generation.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr1_d      = addr1_q;
        wdata1_d     = wdata1_q;
        rd_lo_d      = rd_lo_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        error_d      = 1'b0;
        resp_data_d  = resp_data_q;
        commit       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    op_d = i_op;
                    if (dec_legal) begin
                        state_d     = ST_ACC0;
                        mem_addr_d  = dec_a0;
                        mem_wdata_d = dec_read ? mem_wdata_q : dec_w0;
                        mem_read_d  = dec_read;
                        mem_write_d = !dec_read;
                        addr1_d     = dec_a1;
                        wdata1_d    = dec_w1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACC0: begin
                if (word_count(op_q) == 2'd2) begin
                    state_d     = ST_ACC1;
                    rd_lo_d     = mem_read_q ? i_mem_read_data : rd_lo_q;
                    mem_addr_d  = addr1_q;
                    mem_wdata_d = mem_write_q ? wdata1_q : mem_wdata_q;
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                end else begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_read_q ? {{DATA_WIDTH{1'b0}}, i_mem_read_data} : '0;
                    commit       = 1'b1;
                end
            end
            ST_ACC1: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                resp_data_d  = mem_read_q ? {i_mem_read_data, rd_lo_q} : '0;
                commit       = 1'b1;
            end
            ST_ERR: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                error_d      = 1'b1;
                resp_data_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LOAD;
            addr1_q      <= '0;
            wdata1_q     <= '0;
            rd_lo_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            error_q      <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr1_q      <= addr1_d;
            wdata1_q     <= wdata1_d;
            rd_lo_q      <= rd_lo_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            error_q      <= error_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller with a behavioural data memory
// and a response scoreboard.
module tb_mem_access_controller;

    localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_PUSH = 3'd2,
                           OP_POP = 3'd3, OP_PUSH32 = 3'd4, OP_POP32 = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] addr = 16'h0;
    logic [31:0] data = 32'h0;
    logic        ready, resp_valid, error, mem_read, mem_write;
    logic [31:0] resp_data;
    logic [15:0] sp, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    logic [15:0] mem [0:4095];

    // {check_data, error, data}
    logic [33:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    mem_access_controller dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .i_op             (op),
        .i_addr           (addr),
        .i_data           (data),
        .o_ready          (ready),
        .o_resp_valid     (resp_valid),
        .o_resp_data      (resp_data),
        .o_error          (error),
        .o_sp             (sp),
        .o_mem_address    (mem_addr),
        .o_mem_write_data (mem_wdata),
        .o_mem_read       (mem_read),
        .o_mem_write      (mem_write),
        .i_mem_read_data  (mem_rdata)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // data memory: executes on negedge, read data valid at the next posedge
    always @(negedge clk) begin
        if (mem_write) mem[mem_addr[11:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[11:0]];
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n) check("rw_exclusive", 34'(mem_read & mem_write), 34'd0);
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 34'(resp_valid), 34'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_error", 34'(error), 34'(e[32]));
                if (e[33]) check("resp_data", 34'(resp_data), 34'(e[31:0]));
            end
        end
    end

    // drivers
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [31:0] d);
        op = o; addr = a; data = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input logic chk_data, input logic err, input logic [31:0] d);
        exp_q.push_back({chk_data, err, d});
    endtask

    task automatic check_access(input string tag, input logic rd, input logic wr,
                                input logic [15:0] a, input logic [15:0] wd, input logic chk_wd);
        check({tag, "_read"}, 34'(mem_read), 34'(rd));
        check({tag, "_write"}, 34'(mem_write), 34'(wr));
        check({tag, "_addr"}, 34'(mem_addr), 34'(a));
        if (chk_wd) check({tag, "_wdata"}, 34'(mem_wdata), 34'(wd));
        check({tag, "_ready"}, 34'(ready), 34'd0);
        check({tag, "_rvalid"}, 34'(resp_valid), 34'd0);
    endtask

    task automatic check_done(input string tag, input logic [15:0] exp_sp);
        check({tag, "_rvalid"}, 34'(resp_valid), 34'd1);
        check({tag, "_ready"}, 34'(ready), 34'd1);
        check({tag, "_sp"}, 34'(sp), 34'(exp_sp));
        check({tag, "_ctrl"}, 34'({mem_read, mem_write}), 34'd0);
    endtask

    task automatic err_case(input string tag, input logic [2:0] o, input logic [15:0] a,
                            input logic [15:0] exp_sp);
        expect_resp(1'b1, 1'b1, 32'h0);
        issue(o, a, 32'hFFFF_FFFF);
        check({tag, "_ctrl"}, 34'({mem_read, mem_write}), 34'd0);
        check({tag, "_busy"}, 34'(ready), 34'd0);
        @(posedge clk); #1;
        check({tag, "_err"}, 34'(error), 34'd1);
        check_done(tag, exp_sp);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 34'(ready), 34'd1);
        check("rst_rvalid", 34'(resp_valid), 34'd0);
        check("rst_rdata", 34'(resp_data), 34'd0);
        check("rst_error", 34'(error), 34'd0);
        check("rst_sp", 34'(sp), 34'h0FFF);
        check("rst_ctrl", 34'({mem_read, mem_write}), 34'd0);
        check("rst_addr", 34'(mem_addr), 34'd0);
        check("rst_wdata", 34'(mem_wdata), 34'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // PUSH then POP
        expect_resp(1'b0, 1'b0, 32'h0);
        issue(OP_PUSH, 16'h0, 32'h0000_ABCD);
        check_access("push", 1'b0, 1'b1, 16'h0FFF, 16'hABCD, 1'b1);
        @(posedge clk); #1;
        check_done("push", 16'h0FFE);

        expect_resp(1'b1, 1'b0, 32'h0000_ABCD);
        issue(OP_POP, 16'h0, 32'h0);
        check_access("pop", 1'b1, 1'b0, 16'h0FFF, 16'h0, 1'b0);
        @(posedge clk); #1;
        check_done("pop", 16'h0FFF);

        // PUSH32 then POP32
        expect_resp(1'b0, 1'b0, 32'h0);
        issue(OP_PUSH32, 16'h0, 32'h1234_5678);
        check_access("push32_w0", 1'b0, 1'b1, 16'h0FFF, 16'h1234, 1'b1);
        @(posedge clk); #1;
        check_access("push32_w1", 1'b0, 1'b1, 16'h0FFE, 16'h5678, 1'b1);
        @(posedge clk); #1;
        check_done("push32", 16'h0FFD);

        expect_resp(1'b1, 1'b0, 32'h1234_5678);
        issue(OP_POP32, 16'h0, 32'h0);
        check_access("pop32_w0", 1'b1, 1'b0, 16'h0FFE, 16'h0, 1'b0);
        @(posedge clk); #1;
        check_access("pop32_w1", 1'b1, 1'b0, 16'h0FFF, 16'h0, 1'b0);
        @(posedge clk); #1;
        check_done("pop32", 16'h0FFF);

        // error cases
        err_case("err_pop_empty", OP_POP, 16'h0, 16'h0FFF);
        err_case("err_load_range", OP_LOAD, 16'h1000, 16'h0FFF);
        err_case("err_op7", 3'd7, 16'h0010, 16'h0FFF);
        err_case("err_op6", 3'd6, 16'h0010, 16'h0FFF);

        // highest legal address
        expect_resp(1'b1, 1'b0, 32'h0000_1234);
        issue(OP_LOAD, 16'h0FFF, 32'h0);
        check_access("load_top", 1'b1, 1'b0, 16'h0FFF, 16'h0, 1'b0);
        @(posedge clk); #1;
        check_done("load_top", 16'h0FFF);

        // STORE then LOAD with valid held high
        expect_resp(1'b0, 1'b0, 32'h0);
        op = OP_STORE; addr = 16'h0010; data = 32'h0000_00AA; req_valid = 1'b1;
        @(posedge clk); #1;
        check_access("b2b_store", 1'b0, 1'b1, 16'h0010, 16'h00AA, 1'b1);
        expect_resp(1'b1, 1'b0, 32'h0000_00AA);
        op = OP_LOAD; data = 32'h0;
        @(posedge clk); #1;
        check_done("b2b_store", 16'h0FFF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_access("b2b_load", 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
        @(posedge clk); #1;
        check_done("b2b_load", 16'h0FFF);

        // POP32 with only one word on the stack
        expect_resp(1'b0, 1'b0, 32'h0);
        issue(OP_PUSH, 16'h0, 32'h0000_5555);
        @(posedge clk); #1;
        check_done("push2", 16'h0FFE);
        err_case("err_pop32_short", OP_POP32, 16'h0, 16'h0FFE);

        // reset during the second word of a PUSH32
        issue(OP_PUSH32, 16'h0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("abort_acc1_write", 34'(mem_write), 34'd1);
        rst_n = 1'b0;
        #1;
        check("abort_write_drop", 34'(mem_write), 34'd0);
        check("abort_rvalid", 34'(resp_valid), 34'd0);
        check("abort_sp", 34'(sp), 34'h0FFF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_abort_sp", 34'(sp), 34'h0FFF);
        check("post_abort_ready", 34'(ready), 34'd1);
        check("post_abort_ctrl", 34'({mem_read, mem_write}), 34'd0);

        check("queue_drained", 34'(exp_q.size()), 34'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Initiator side of the data-memory interface in the execute-memory stage.
- Takes one memory request from the pipeline and turns it into one or two single-word accesses on the data-memory port: LOAD, STORE, PUSH, POP, PUSH32, POP32.
- Owns the stack pointer, stalls the pipeline while busy and returns read data plus a completion or error pulse.
- Drives the data-memory controls from posedge registers; memory executes on the negedge of the same cycle.

Parameters:
- DATA_WIDTH, 16, memory word width.
- ADDR_WIDTH, 16, memory address width.
- MEM_DEPTH, 4096, number of valid words; addresses 0..MEM_DEPTH-1.
- STACK_TOP, 16'h0FFF, SP reset value; points to the next free slot.

Ports:
- i_clk  in  1  clock; all state on posedge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request present; accepted on posedge when o_ready=1.
- i_op  in  3  opcode: LOAD=0, STORE=1, PUSH=2, POP=3, PUSH32=4, POP32=5; 6 and 7 are illegal.
- i_addr  in  16  word address for LOAD/STORE.
- i_data  in  32  store/push data; [15:0] used for single-word ops.
- o_ready  out  1  1 in IDLE; the pipeline stalls while 0.
- o_resp_valid  out  1  one-cycle completion pulse.
- o_resp_data  out  32  read result; single-word reads are zero-extended.
- o_error  out  1  qualified by o_resp_valid; range or stack violation, or illegal op.
- o_sp  out  16  current stack pointer.
- o_mem_address  out  16  to data memory.
- o_mem_write_data  out  16  to data memory.
- o_mem_read  out  1  to data memory.
- o_mem_write  out  1  to data memory.
- i_mem_read_data  in  16  from data memory; valid at the posedge after the read cycle.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, o_ready=1, SP=STACK_TOP.
  - o_resp_valid=0, o_resp_data=0, o_error=0.
  - o_mem_read=0, o_mem_write=0, o_mem_address=0, o_mem_write_data=0.
  - Reset during an access aborts it immediately; controls drop asynchronously, no response pulse, SP is restored to STACK_TOP.
- FSM states: IDLE, ACC0, ACC1, ERR.
- IDLE, accept (i_req_valid and o_ready): latch op, address and data, then check legality.
  - Legal request: go to ACC0 and drive the word-0 access.
  - Illegal request: go to ERR; no memory control is asserted.
- ACC0 (one cycle): the memory performs the access at negedge.
  - At the next posedge, capture i_mem_read_data if the access was a read.
  - 32-bit op: go to ACC1 and drive the word-1 access.
  - Otherwise: go to IDLE, pulse o_resp_valid and update SP.
- ACC1 (one cycle): same as ACC0, then go to IDLE with o_resp_valid and the SP update.
- ERR (one cycle): o_resp_valid=1, o_error=1, o_resp_data=0, SP unchanged, then back to IDLE.
- Latency from accept edge to o_resp_valid high:
  - 1 cycle for single-word ops and for errors.
  - 2 cycles for 32-bit ops.
  - o_ready is low for exactly those cycles; throughput is one op per 2 cycles (single-word) or per 3 cycles (32-bit).
- Access map (SP means the value at accept):
  - LOAD: read at i_addr.
  - STORE: write i_data[15:0] to i_addr.
  - PUSH: write i_data[15:0] to SP; SP becomes SP-1.
  - POP: read at SP+1; SP becomes SP+1.
  - PUSH32: write i_data[31:16] to SP, then i_data[15:0] to SP-1; SP becomes SP-2.
  - POP32: read the low word at SP+1, then the high word at SP+2; SP becomes SP+2.
- Error conditions (all arithmetic 16-bit, unsigned):
  - LOAD/STORE with i_addr >= MEM_DEPTH.
  - PUSH with SP=16'hFFFF (stack full).
  - PUSH32 with SP < 1.
  - POP with SP+1 > STACK_TOP.
  - POP32 with SP+2 > STACK_TOP.
  - Illegal opcode.
- Invariants:
  - o_mem_read and o_mem_write are never both 1.
  - Both controls are 0 outside ACC0 and ACC1.
  - o_mem_address and o_mem_write_data hold their last value when the controls are 0.
- i_req_valid while o_ready=0 is ignored; the request is not queued.
- o_resp_data holds its value until the next response.

Decomposition:
- Package mem_ctrl_pkg holds:
  - opcode localparams and the FSM state encodings;
  - MEM_DEPTH and STACK_TOP defaults;
  - word-count function per op (1 or 2).
- Sub-module stack_pointer holds:
  - the SP register with async active-low reset;
  - combinational push/pop legality checks;
  - a commit strobe that applies the +/-1 or +/-2 update.

Test Plan:
- Reset then PUSH data 32'h0000_ABCD at SP=0FFF -> o_mem_write=1, addr=0FFF, wdata=ABCD for one cycle; o_resp_valid=1, o_error=0 next; o_sp=0FFE.
- Follow with POP -> read at 0FFF, o_resp_data=0000_ABCD, o_sp=0FFF.
- PUSH32 32'h1234_5678 then POP32:
  - PUSH32 writes 1234 at 0FFF and 5678 at 0FFE, SP=0FFD;
  - POP32 returns 1234_5678 and SP=0FFF;
  - o_ready low for exactly 2 cycles per op.
- POP at SP=0FFF, LOAD at addr 1000, and op=7 -> each gives o_resp_valid and o_error=1 one cycle after accept, no memory control asserted, SP unchanged.
- STORE 0x00AA to addr 0010 then LOAD 0010 back-to-back (valid held high) -> second op accepted 2 cycles after the first, returns 0000_00AA.
- Assert i_rst_n=0 mid-PUSH32 during ACC1 -> o_mem_write drops immediately, no o_resp_valid, o_sp=0FFF after release.
